// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types, constants and width helpers for the
//                virtual-channel router switch allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Per-output allocation state: free, or held by one input for a packet.
    typedef enum logic [0:0] {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } sa_state_e;

    localparam int NUM_PORTS_DEF = 5;
    localparam int PORT_W        = $clog2(NUM_PORTS_DEF);

    // Width of a port index; never collapses to zero bits.
    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a credit counter able to hold 0..credits inclusive.
    function automatic int credit_w(input int credits);
        return (credits > 0) ? $clog2(credits + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first active
//                request found scanning upward (with wrap) from the pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import router_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [port_w(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    localparam int c_pw = port_w(N);

    logic [c_pw-1:0] w_idx;
    logic            w_found;

    // Priority scan starting at the pointer; the first hit wins.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = c_pw'((int'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Separable input-first switch allocator. Round-robin input
//                and output stages, per-packet output locking and per-output
//                credit gating. Grants and crossbar selects are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int NUM_VC    = 2,
    parameter int CREDITS   = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]           port_req,
    input  logic [NUM_PORTS-1:0]                          req_tail,
    input  logic [NUM_PORTS-1:0]                          credit_return,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]           sa_grant,
    output logic [NUM_PORTS-1:0][port_w(NUM_PORTS)-1:0]   xbar_sel,
    output logic [NUM_PORTS-1:0]                          xbar_valid,
    output logic [NUM_PORTS-1:0][credit_w(CREDITS)-1:0]   credit_cnt
);

    localparam int c_pw = port_w(NUM_PORTS);
    localparam int c_cw = credit_w(CREDITS);
    localparam logic [c_cw-1:0] c_credit_max = c_cw'(CREDITS);
    localparam logic [c_cw-1:0] c_credit_one = c_cw'(1);

    // Degenerate configurations are rejected at elaboration.
    if (NUM_PORTS < 2 || NUM_VC < 1 || CREDITS < 1) begin : g_bad_params
        $error("switch_allocator: unsupported parameter set");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sa_state_e                          r_state [NUM_PORTS];
    logic [NUM_PORTS-1:0][c_pw-1:0]     r_owner;
    logic [NUM_PORTS-1:0][c_pw-1:0]     r_out_ptr;
    logic [NUM_PORTS-1:0][c_pw-1:0]     r_in_ptr;
    logic [NUM_PORTS-1:0][c_cw-1:0]     r_credit;

    // ------------------------------------------------------------------
    // Combinational allocation
    // ------------------------------------------------------------------
    // [i][j] indexed by input then output
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_own;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_s1_gnt;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_gnt;
    logic [NUM_PORTS-1:0]                w_in_locked;
    // [j][i] indexed by output then input
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_s2_req;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_s2_gnt;

    logic [NUM_PORTS-1:0]                w_col_any;
    logic [NUM_PORTS-1:0][c_pw-1:0]      w_col_idx;
    logic [NUM_PORTS-1:0]                w_col_tail;
    logic [NUM_PORTS-1:0]                w_row_any;
    logic [NUM_PORTS-1:0][c_pw-1:0]      w_row_next;

    // Eligibility: credit available and output free or owned by this input;
    // a lock owner only competes for its locked output.
    always_comb begin
        w_own       = '0;
        w_elig      = '0;
        w_in_locked = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                w_own[i][j] = (r_state[j] == SA_LOCKED) && (r_owner[j] == c_pw'(i));
            end
            w_in_locked[i] = |w_own[i];
            for (int j = 0; j < NUM_PORTS; j++) begin
                w_elig[i][j] = port_req[i][j] && (r_credit[j] != '0) &&
                               (w_in_locked[i] ? w_own[i][j] : (r_state[j] == SA_IDLE));
            end
        end
    end

    // Stage 1: each input picks one eligible output.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in_arb
        rr_arbiter #(
            .N     (NUM_PORTS)
        ) u_in_arb (
            .req   (w_elig[gi]),
            .ptr   (r_in_ptr[gi]),
            .grant (w_s1_gnt[gi])
        );
    end

    // Transpose stage-1 picks into per-output request columns.
    always_comb begin
        w_s2_req = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_s2_req[j][i] = w_s1_gnt[i][j];
            end
        end
    end

    // Stage 2: each output picks one of the inputs that chose it.
    for (genvar gj = 0; gj < NUM_PORTS; gj++) begin : g_out_arb
        rr_arbiter #(
            .N     (NUM_PORTS)
        ) u_out_arb (
            .req   (w_s2_req[gj]),
            .ptr   (r_out_ptr[gj]),
            .grant (w_s2_gnt[gj])
        );
    end

    // Final grant matrix plus per-output winner encode and per-input next pointer.
    always_comb begin
        w_gnt      = '0;
        w_col_any  = '0;
        w_col_idx  = '0;
        w_col_tail = '0;
        w_row_any  = '0;
        w_row_next = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_col_any[j] = |w_s2_gnt[j];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_s2_gnt[j][i]) begin
                    w_col_idx[j]  = c_pw'(i);
                    w_col_tail[j] = req_tail[i];
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                w_gnt[i][j] = w_s2_gnt[j][i];
                if (w_s2_gnt[j][i]) begin
                    w_row_any[i]  = 1'b1;
                    w_row_next[i] = c_pw'((j + 1) % NUM_PORTS);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Lock, pointer and credit bookkeeping; updates land on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_state[j] <= SA_IDLE;
            end
            r_owner   <= '0;
            r_out_ptr <= '0;
            r_in_ptr  <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_credit[j] <= c_credit_max;
            end
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                // A lock is released only by a granted tail; stalls keep it.
                if (w_col_any[j]) begin
                    if (w_col_tail[j]) begin
                        r_state[j]   <= SA_IDLE;
                        r_out_ptr[j] <= c_pw'((int'(w_col_idx[j]) + 1) % NUM_PORTS);
                    end else begin
                        r_state[j] <= SA_LOCKED;
                        r_owner[j] <= w_col_idx[j];
                    end
                end
                // A grant always implies a nonzero count, so no underflow.
                case ({w_col_any[j], credit_return[j]})
                    2'b10: r_credit[j] <= r_credit[j] - c_credit_one;
                    2'b01: begin
                        if (r_credit[j] != c_credit_max) begin
                            r_credit[j] <= r_credit[j] + c_credit_one;
                        end
                    end
                    default: r_credit[j] <= r_credit[j];
                endcase
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_row_any[i]) begin
                    r_in_ptr[i] <= w_row_next[i];
                end
            end
        end
    end

    // Registered outputs driving switch traversal next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_grant   <= '0;
            xbar_sel   <= '0;
            xbar_valid <= '0;
        end else begin
            sa_grant   <= w_gnt;
            xbar_sel   <= w_col_idx;
            xbar_valid <= w_col_any;
        end
    end

    assign credit_cnt = r_credit;

endmodule
`default_nettype wire
